// File: rtl/wbc_cmd_master_pkg.sv
// ---------------------------------------------------------------------------
// wbc_cmd_master_pkg
//   Shared types for the command-to-WISHBONE master: bus widths, controller
//   states, response status codes and the latched command record.
// ---------------------------------------------------------------------------
package wbc_cmd_master_pkg;

  localparam int ADR_W = 20;
  localparam int DAT_W = 32;
  localparam int SEL_W = 4;

  // Controller states; exactly one bus transaction is ever in flight.
  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_BUS        = 2'd1,
    ST_RETRY_WAIT = 2'd2,
    ST_RESP       = 2'd3
  } state_e;

  // Response status codes seen on rsp_status_o.
  typedef enum logic [1:0] {
    RSP_OK              = 2'b00,
    RSP_ERR             = 2'b01,
    RSP_TIMEOUT         = 2'b10,
    RSP_RETRY_EXHAUSTED = 2'b11
  } rsp_status_e;

  // Command captured at acceptance and replayed on every (re-)issue.
  typedef struct packed {
    logic             we;
    logic [ADR_W-1:0] adr;
    logic [DAT_W-1:0] dat;
    logic [SEL_W-1:0] sel;
  } cmd_t;

endpackage

// File: rtl/wbc_cmd_master.sv
// ---------------------------------------------------------------------------
// wbc_cmd_master
//   Turns single commands from a valid/ready command port into classic
//   WISHBONE single cycles and returns one response per command.
//   A bus cycle ends on ack (ok), err (error), rty (re-issued up to MAX_RETRY
//   times with one idle cycle in between, then "retry exhausted") or after
//   TIMEOUT cycles without any termination (timeout).
//
// Parameters
//   TIMEOUT   : BUS-state cycles allowed without ack/err/rty (2..65535)
//   MAX_RETRY : re-issues after rty before giving up (0..15)
//
// Ports
//   clk_i, rst_i           : clock, synchronous active-high reset
//   cmd_valid_i/ready_o    : command handshake (ready only in IDLE)
//   cmd_we_i/adr_i/dat_i/sel_i : command fields
//   rsp_valid_o/ready_i    : response handshake
//   rsp_dat_o              : read data (0 for writes and failures)
//   rsp_status_o           : 00 ok, 01 err, 10 timeout, 11 retry exhausted
//   wbm_*                  : WISHBONE master port, all outputs registered
// ---------------------------------------------------------------------------
module wbc_cmd_master
  import wbc_cmd_master_pkg::*;
#(
  parameter int unsigned TIMEOUT   = 255,
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  // command port
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic             cmd_we_i,
  input  logic [ADR_W-1:0] cmd_adr_i,
  input  logic [DAT_W-1:0] cmd_dat_i,
  input  logic [SEL_W-1:0] cmd_sel_i,
  // response port
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [DAT_W-1:0] rsp_dat_o,
  output logic [1:0]       rsp_status_o,
  // WISHBONE master
  output logic             wbm_cyc_o,
  output logic             wbm_stb_o,
  output logic             wbm_we_o,
  output logic [ADR_W-1:0] wbm_adr_o,
  output logic [DAT_W-1:0] wbm_dat_o,
  output logic [SEL_W-1:0] wbm_sel_o,
  input  logic             wbm_ack_i,
  input  logic             wbm_err_i,
  input  logic             wbm_rty_i,
  input  logic [DAT_W-1:0] wbm_dat_i
);

  localparam logic [15:0] TO_LAST   = 16'(TIMEOUT - 1);
  localparam logic [3:0]  RETRY_MAX = 4'(MAX_RETRY);

  state_e      state;
  cmd_t        cmd_q;
  logic [15:0] to_cnt;
  logic [3:0]  retry_cnt;
  logic        ready_q;
  logic        cyc_q;
  logic        we_q;
  logic        rsp_valid_q;
  logic [DAT_W-1:0] rsp_dat_q;
  rsp_status_e rsp_status_q;

  // NOTE: every register here is updated with non-blocking assignments so
  // all state moves together on the edge regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= ST_IDLE;
      cmd_q        <= '0;
      to_cnt       <= '0;
      retry_cnt    <= '0;
      ready_q      <= 1'b0;
      cyc_q        <= 1'b0;
      we_q         <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_dat_q    <= '0;
      rsp_status_q <= RSP_OK;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid_i && ready_q) begin
            cmd_q.we  <= cmd_we_i;
            cmd_q.adr <= cmd_adr_i;
            cmd_q.dat <= cmd_dat_i;
            cmd_q.sel <= cmd_sel_i;
            retry_cnt <= '0;
            to_cnt    <= '0;
            ready_q   <= 1'b0;
            cyc_q     <= 1'b1;
            we_q      <= cmd_we_i;
            state     <= ST_BUS;
          end else begin
            // Ready rises one cycle after reset release and stays up in IDLE.
            ready_q <= 1'b1;
          end
        end

        ST_BUS: begin
          // Terminations are checked in priority order ack > err > rty,
          // and any of them beats a timeout in the same cycle.
          if (wbm_ack_i) begin
            cyc_q        <= 1'b0;
            we_q         <= 1'b0;
            rsp_valid_q  <= 1'b1;
            rsp_dat_q    <= cmd_q.we ? '0 : wbm_dat_i;
            rsp_status_q <= RSP_OK;
            state        <= ST_RESP;
          end else if (wbm_err_i) begin
            cyc_q        <= 1'b0;
            we_q         <= 1'b0;
            rsp_valid_q  <= 1'b1;
            rsp_dat_q    <= '0;
            rsp_status_q <= RSP_ERR;
            state        <= ST_RESP;
          end else if (wbm_rty_i) begin
            cyc_q <= 1'b0;
            we_q  <= 1'b0;
            if (retry_cnt < RETRY_MAX) begin
              retry_cnt <= retry_cnt + 4'd1;
              state     <= ST_RETRY_WAIT;
            end else begin
              rsp_valid_q  <= 1'b1;
              rsp_dat_q    <= '0;
              rsp_status_q <= RSP_RETRY_EXHAUSTED;
              state        <= ST_RESP;
            end
          end else if (to_cnt == TO_LAST) begin
            cyc_q        <= 1'b0;
            we_q         <= 1'b0;
            rsp_valid_q  <= 1'b1;
            rsp_dat_q    <= '0;
            rsp_status_q <= RSP_TIMEOUT;
            state        <= ST_RESP;
          end else begin
            to_cnt <= to_cnt + 16'd1;
          end
        end

        ST_RETRY_WAIT: begin
          // One idle cycle, then re-issue the same command with a fresh
          // timeout window. Address/data/sel are still held in cmd_q.
          to_cnt <= '0;
          cyc_q  <= 1'b1;
          we_q   <= cmd_q.we;
          state  <= ST_BUS;
        end

        ST_RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_q  <= 1'b0;
            rsp_dat_q    <= '0;
            rsp_status_q <= RSP_OK;
            ready_q      <= 1'b1;
            state        <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready_o  = ready_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_dat_o    = rsp_dat_q;
  assign rsp_status_o = rsp_status_q;
  assign wbm_cyc_o    = cyc_q;
  assign wbm_stb_o    = cyc_q;
  assign wbm_we_o     = we_q;
  assign wbm_adr_o    = cmd_q.adr;
  assign wbm_dat_o    = cmd_q.dat;
  assign wbm_sel_o    = cmd_q.sel;

endmodule

// File: tb/tb_wbc_cmd_master.sv
// ---------------------------------------------------------------------------
// tb_wbc_cmd_master
//   Self-checking bench for wbc_cmd_master (TIMEOUT=8, MAX_RETRY=3).
//   A scripted slave answers each bus attempt with a chosen set of
//   terminations after a chosen delay; a transaction-level model derives the
//   expected attempt lengths, final status and data from the protocol rules.
// ---------------------------------------------------------------------------
module tb_wbc_cmd_master;

  localparam int TO = 8;
  localparam int MR = 3;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic        cmd_we_i;
  logic [19:0] cmd_adr_i;
  logic [31:0] cmd_dat_i;
  logic [3:0]  cmd_sel_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_dat_o;
  logic [1:0]  rsp_status_o;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [19:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [3:0]  wbm_sel_o;
  logic        wbm_ack_i;
  logic        wbm_err_i;
  logic        wbm_rty_i;
  logic [31:0] wbm_dat_i;

  wbc_cmd_master #(.TIMEOUT(TO), .MAX_RETRY(MR)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .cmd_valid_i  (cmd_valid_i),
    .cmd_ready_o  (cmd_ready_o),
    .cmd_we_i     (cmd_we_i),
    .cmd_adr_i    (cmd_adr_i),
    .cmd_dat_i    (cmd_dat_i),
    .cmd_sel_i    (cmd_sel_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_dat_o    (rsp_dat_o),
    .rsp_status_o (rsp_status_o),
    .wbm_cyc_o    (wbm_cyc_o),
    .wbm_stb_o    (wbm_stb_o),
    .wbm_we_o     (wbm_we_o),
    .wbm_adr_o    (wbm_adr_o),
    .wbm_dat_o    (wbm_dat_o),
    .wbm_sel_o    (wbm_sel_o),
    .wbm_ack_i    (wbm_ack_i),
    .wbm_err_i    (wbm_err_i),
    .wbm_rty_i    (wbm_rty_i),
    .wbm_dat_i    (wbm_dat_i)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // Current command and slave script: per attempt, the termination set
  // {rty,err,ack} and the bus cycle index at which it is presented.
  logic        t_we;
  logic [19:0] t_adr;
  logic [31:0] t_dat;
  logic [3:0]  t_sel;
  logic [31:0] t_rdata;
  logic [2:0]  t_mask  [16];
  int          t_delay [16];

  // Model outputs.
  int          exp_len [16];
  int          exp_n;
  logic [1:0]  exp_status;
  logic [31:0] exp_dat;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_quiet();
    wbm_ack_i = 1'b0;
    wbm_err_i = 1'b0;
    wbm_rty_i = 1'b0;
    wbm_dat_i = $urandom;
  endtask

  // Random terminations while no cycle is open; the master must ignore them.
  task automatic drive_noise();
    {wbm_rty_i, wbm_err_i, wbm_ack_i} = 3'($urandom_range(0, 7));
    wbm_dat_i = $urandom;
  endtask

  task automatic set_cmd(input logic we, input logic [19:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input logic [31:0] rdata);
    t_we = we; t_adr = adr; t_dat = dat; t_sel = sel; t_rdata = rdata;
  endtask

  task automatic set_script(input logic [2:0] mask, input int delay);
    for (int a = 0; a < 16; a++) begin
      t_mask[a]  = mask;
      t_delay[a] = delay;
    end
  endtask

  // Transaction-level reference: walk the attempts the slave script implies.
  task automatic compute_expected();
    int retries;
    int win;   // 0 ack, 1 err, 2 rty, 3 timeout
    retries = 0;
    exp_n = 0;
    exp_status = 2'b00;
    exp_dat = 32'h0;
    for (int a = 0; a < 16; a++) begin
      if (t_mask[a] != 3'b000 && t_delay[a] < TO) begin
        exp_len[a] = t_delay[a] + 1;
        win = t_mask[a][0] ? 0 : (t_mask[a][1] ? 1 : 2);
      end else begin
        exp_len[a] = TO;
        win = 3;
      end
      exp_n = a + 1;
      if (win == 2 && retries < MR) begin
        retries++;
      end else begin
        case (win)
          0:       begin exp_status = 2'b00; exp_dat = t_we ? 32'h0 : t_rdata; end
          1:       exp_status = 2'b01;
          2:       exp_status = 2'b11;
          default: exp_status = 2'b10;
        endcase
        break;
      end
    end
  endtask

  task automatic run_txn(input string name, input int hold);
    int waitc;
    int len;
    compute_expected();
    cmd_valid_i = 1'b1;
    cmd_we_i    = t_we;
    cmd_adr_i   = t_adr;
    cmd_dat_i   = t_dat;
    cmd_sel_i   = t_sel;
    drive_noise();
    waitc = 0;
    while (!cmd_ready_o && waitc < 20) begin
      tick();
      drive_noise();
      waitc++;
    end
    check({name, " cmd_ready"}, 64'(cmd_ready_o), 64'd1);
    tick();
    cmd_valid_i = 1'b0;
    cmd_we_i    = 1'($urandom);
    cmd_adr_i   = 20'($urandom);
    cmd_dat_i   = $urandom;
    cmd_sel_i   = 4'($urandom);
    check({name, " ready_low"}, 64'(cmd_ready_o), 64'd0);

    for (int a = 0; a < exp_n; a++) begin
      check($sformatf("%s a%0d cyc_start", name, a), 64'(wbm_cyc_o), 64'd1);
      len = 0;
      while (wbm_cyc_o && len < TO + 4) begin
        check($sformatf("%s a%0d stb", name, a), 64'(wbm_stb_o), 64'd1);
        check($sformatf("%s a%0d adr", name, a), 64'(wbm_adr_o), 64'(t_adr));
        check($sformatf("%s a%0d dat", name, a), 64'(wbm_dat_o), 64'(t_dat));
        check($sformatf("%s a%0d sel", name, a), 64'(wbm_sel_o), 64'(t_sel));
        check($sformatf("%s a%0d we", name, a), 64'(wbm_we_o), 64'(t_we));
        drive_quiet();
        if (len == t_delay[a]) {wbm_rty_i, wbm_err_i, wbm_ack_i} = t_mask[a];
        if (wbm_ack_i) wbm_dat_i = t_rdata;
        tick();
        len++;
      end
      drive_noise();
      check($sformatf("%s a%0d cyc_len", name, a), 64'(len), 64'(exp_len[a]));
      check($sformatf("%s a%0d stb_off", name, a), 64'(wbm_stb_o), 64'd0);
      check($sformatf("%s a%0d we_off", name, a), 64'(wbm_we_o), 64'd0);
      if (a < exp_n - 1) begin
        check($sformatf("%s a%0d no_rsp", name, a), 64'(rsp_valid_o), 64'd0);
        tick();   // the single idle cycle between attempts
      end
    end

    check({name, " rsp_valid"}, 64'(rsp_valid_o), 64'd1);
    check({name, " status"}, 64'(rsp_status_o), 64'(exp_status));
    check({name, " rsp_dat"}, 64'(rsp_dat_o), 64'(exp_dat));
    rsp_ready_i = 1'b0;
    for (int h = 0; h < hold; h++) begin
      drive_noise();
      tick();
      check($sformatf("%s hold%0d valid", name, h), 64'(rsp_valid_o), 64'd1);
      check($sformatf("%s hold%0d status", name, h), 64'(rsp_status_o), 64'(exp_status));
      check($sformatf("%s hold%0d dat", name, h), 64'(rsp_dat_o), 64'(exp_dat));
      check($sformatf("%s hold%0d ready", name, h), 64'(cmd_ready_o), 64'd0);
      check($sformatf("%s hold%0d cyc", name, h), 64'(wbm_cyc_o), 64'd0);
    end
    rsp_ready_i = 1'b1;
    drive_noise();
    tick();
    rsp_ready_i = 1'b0;
    check({name, " rsp_done"}, 64'(rsp_valid_o), 64'd0);
    check({name, " idle_ready"}, 64'(cmd_ready_o), 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i       = 1'b1;
    cmd_valid_i = 1'b1;
    cmd_we_i    = 1'b1;
    cmd_adr_i   = 20'hFFFFF;
    cmd_dat_i   = 32'hFFFF_FFFF;
    cmd_sel_i   = 4'hF;
    rsp_ready_i = 1'b0;
    drive_noise();

    // Reset: every output held at zero.
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("rst%0d ready", i), 64'(cmd_ready_o), 64'd0);
      check($sformatf("rst%0d cyc", i), 64'(wbm_cyc_o), 64'd0);
      check($sformatf("rst%0d stb", i), 64'(wbm_stb_o), 64'd0);
      check($sformatf("rst%0d we", i), 64'(wbm_we_o), 64'd0);
      check($sformatf("rst%0d adr", i), 64'(wbm_adr_o), 64'd0);
      check($sformatf("rst%0d rsp_valid", i), 64'(rsp_valid_o), 64'd0);
      check($sformatf("rst%0d rsp_dat", i), 64'(rsp_dat_o), 64'd0);
      check($sformatf("rst%0d status", i), 64'(rsp_status_o), 64'd0);
    end
    rst_i       = 1'b0;
    cmd_valid_i = 1'b0;
    tick();
    check("post_rst ready", 64'(cmd_ready_o), 64'd1);
    check("post_rst cyc", 64'(wbm_cyc_o), 64'd0);

    // Read, ack on the third bus cycle.
    set_cmd(1'b0, 20'h12345, 32'h0, 4'hF, 32'hDEAD_BEEF);
    set_script(3'b001, 2);
    run_txn("read_ack3", 1);

    // Write, ack on the first bus cycle.
    set_cmd(1'b1, 20'h80004, 32'hA5A5_A5A5, 4'hF, 32'h1234_5678);
    set_script(3'b001, 0);
    run_txn("write_ack0", 0);

    // Slave always answers rty: four attempts, then retry exhausted.
    set_cmd(1'b1, 20'h00ABC, 32'h0BAD_F00D, 4'h3, 32'h0);
    set_script(3'b100, 0);
    run_txn("rty_always", 2);

    // No slave response at all: timeout after TO cycles.
    set_cmd(1'b0, 20'h54321, 32'h0, 4'h1, 32'hCAFE_0001);
    set_script(3'b000, 0);
    run_txn("timeout", 1);

    // Termination on the last cycle before timeout still wins.
    set_cmd(1'b0, 20'h00777, 32'h0, 4'hC, 32'h7777_0000);
    set_script(3'b010, TO - 1);
    run_txn("err_at_edge", 0);

    // ack and err together: ack has priority; long response back-pressure.
    set_cmd(1'b0, 20'h0F0F0, 32'h0, 4'hF, 32'h5555_AAAA);
    set_script(3'b011, 1);
    run_txn("ack_err", 5);

    // rty twice then ack.
    set_cmd(1'b0, 20'h11111, 32'h0, 4'h6, 32'h0123_4567);
    set_script(3'b100, 1);
    t_mask[2] = 3'b001;
    t_delay[2] = 3;
    run_txn("rty2_ack", 1);

    // Reset in the middle of a bus cycle: cycle dropped, no response.
    set_cmd(1'b1, 20'h22222, 32'h2222_2222, 4'hF, 32'h0);
    cmd_valid_i = 1'b1;
    cmd_we_i    = t_we;
    cmd_adr_i   = t_adr;
    cmd_dat_i   = t_dat;
    cmd_sel_i   = t_sel;
    drive_quiet();
    tick();
    cmd_valid_i = 1'b0;
    tick();
    tick();
    check("midrst bus_open", 64'(wbm_cyc_o), 64'd1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check("midrst cyc", 64'(wbm_cyc_o), 64'd0);
    check("midrst stb", 64'(wbm_stb_o), 64'd0);
    check("midrst rsp", 64'(rsp_valid_o), 64'd0);
    for (int i = 0; i < 6; i++) begin
      drive_noise();
      tick();
      check($sformatf("midrst after%0d rsp", i), 64'(rsp_valid_o), 64'd0);
      check($sformatf("midrst after%0d cyc", i), 64'(wbm_cyc_o), 64'd0);
    end
    check("midrst ready", 64'(cmd_ready_o), 64'd1);

    // Randomised transactions.
    for (int n = 0; n < 40; n++) begin
      int r;
      set_cmd(1'($urandom), 20'($urandom), $urandom, 4'($urandom), $urandom);
      for (int a = 0; a < 16; a++) begin
        r = $urandom_range(0, 9);
        if (r < 2)      t_mask[a] = 3'b000;
        else if (r < 5) t_mask[a] = 3'b100;
        else            t_mask[a] = 3'($urandom_range(1, 7));
        t_delay[a] = $urandom_range(0, TO + 1);
      end
      run_txn($sformatf("rnd%0d", n), $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wbc_cmd_master.md
WBC_CMD_MASTER -- requirements
Module: wbc_cmd_master

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning the number of BUS-state cycles allowed without ack/err/rty (range 2..65535).
REQ-002 SHALL have parameter MAX_RETRY, default 3, meaning the number of re-issues after rty before giving up (range 0..15).
REQ-003 SHALL use one clock and a synchronous, active-high reset, with ports named clk_i and rst_i as in the rest of the codebase.
REQ-004 SHALL have these ports (name, direction, width, meaning):
- clk_i, in, 1, clock.
- rst_i, in, 1, synchronous active-high reset.
- cmd_valid_i, in, 1, command present.
- cmd_ready_o, out, 1, command accepted this cycle.
- cmd_we_i, in, 1, 1 = write.
- cmd_adr_i, in, 20, address.
- cmd_dat_i, in, 32, write data.
- cmd_sel_i, in, 4, byte selects.
- rsp_valid_o, out, 1, response present.
- rsp_ready_i, in, 1, response consumed.
- rsp_dat_o, out, 32, read data (0 for writes and failures).
- rsp_status_o, out, 2, status: 00 ok, 01 err, 10 timeout, 11 retry exhausted.
- wbm_cyc_o, wbm_stb_o, wbm_we_o, out, 1 each, WISHBONE master controls.
- wbm_adr_o, out, 20, address.
- wbm_dat_o, out, 32, write data.
- wbm_sel_o, out, 4, byte selects.
- wbm_ack_i, wbm_err_i, wbm_rty_i, in, 1 each, WISHBONE cycle terminations.
- wbm_dat_i, in, 32, read data.

Function
REQ-005 SHALL implement states IDLE, BUS, RETRY_WAIT and RESP, with at most one transaction outstanding.
REQ-006 IDLE: cmd_ready_o=1; on cmd_valid_i&&cmd_ready_o SHALL latch we/adr/dat/sel, clear the retry count and go to BUS.
REQ-007 Latency: a command accepted at edge N SHALL give wbm_cyc_o=wbm_stb_o=1 from cycle N+1; all wbm_* outputs SHALL be registered.
REQ-008 wbm_adr_o, wbm_dat_o, wbm_sel_o and wbm_we_o SHALL be constant while wbm_cyc_o=1; wbm_we_o SHALL be 0 whenever wbm_cyc_o=0.
REQ-009 BUS: the timeout counter SHALL start at 0 on each BUS entry and increment each BUS cycle.
REQ-010 BUS termination priority SHALL be ack > err > rty > timeout when events coincide.
REQ-011 ack: SHALL capture wbm_dat_i for reads (0 for writes), set status 00 and go to RESP.
REQ-012 err: SHALL set status 01, rsp_dat_o=0, go to RESP.
REQ-013 rty with retry count < MAX_RETRY: SHALL increment the count and go to RETRY_WAIT, where cyc/stb are low for exactly 1 cycle, then return to BUS.
REQ-014 rty with retry count == MAX_RETRY: SHALL set status 11 and go to RESP.
REQ-015 When the counter reaches TIMEOUT-1 with no termination, SHALL set status 10, rsp_dat_o=0 and go to RESP.
REQ-016 When a termination is sampled at edge M, wbm_cyc_o/wbm_stb_o SHALL be 0 and rsp_valid_o SHALL be 1 from cycle M+1.
REQ-017 RESP: rsp_valid_o=1 with rsp_dat_o/rsp_status_o stable until rsp_valid_o&&rsp_ready_i, then IDLE; cmd_ready_o=0 outside IDLE.
REQ-018 ack/err/rty seen outside BUS SHALL be ignored.

Reset
REQ-019 While rst_i=1, SHALL force all outputs to 0 (including cmd_ready_o) and the state to IDLE; cmd_ready_o=1 the first cycle after release.
REQ-020 Reset asserted mid-cycle SHALL drop wbm_cyc_o/wbm_stb_o at the next edge and SHALL produce no response.

Structure
REQ-021 Status codes SHALL be shared defines in a header alongside wishbone.vh; port groups SHALL use the existing WBM naming macro with prefix wbm.
REQ-022 SHALL be a single module with no sub-modules; the timeout and retry counters are inline.

Verification
REQ-023 Read adr 0x12345, slave acks after 3 cycles with 0xDEADBEEF -> cyc high 3 cycles, rsp_dat_o=0xDEADBEEF, status 00.
REQ-024 Write adr 0x80004, dat 0xA5A5A5A5, sel 0xF, ack in first BUS cycle -> wbm_we_o=1 for 1 cycle only, rsp_dat_o=0, status 00.
REQ-025 With MAX_RETRY=3, slave always rty -> 4 bus cycles each separated by 1 idle cycle, then status 11.
REQ-026 With TIMEOUT=8, no slave response -> cyc high exactly 8 cycles, status 10.
REQ-027 ack and err in the same cycle -> status 00; holding rsp_ready_i low 5 cycles -> rsp stable and cmd_ready_o=0; rst_i pulse mid-BUS -> cyc 0 next edge and no rsp_valid_o.
